bsm_arbiter: RTL and testbench
==============================

Name: bsm_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one bit-serial multiplier among N_REQ requesters.
- Accepts operand pairs from requesters and issues each to the multiplier as a one-cycle start pulse.
- Waits for the multiplier's done pulse, or a watchdog timeout, then returns the product tagged with the requester ID over a valid/ready response port.
- Sits between client blocks and the bit-serial multiplier plus its load/shift controller.

Parameters:
- NB_DATA, 4, operand width in bits; product width is 2*NB_DATA.
- N_REQ, 4, number of requesters; must be >= 2.
- TIMEOUT, 32, maximum cycles allowed in WAIT before the error response; must be > NB_DATA+2.

Ports:
- i_clk  in  1  clock, all logic on the rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req  in  N_REQ  per-requester request level; held until granted.
- i_op_a  in  N_REQ*NB_DATA  packed operand A; slice k belongs to requester k.
- i_op_b  in  N_REQ*NB_DATA  packed operand B; slice k belongs to requester k.
- o_gnt  out  N_REQ  one-hot, one-cycle pulse: operands of that requester latched.
- o_mul_start  out  1  one-cycle start/load pulse to the multiplier.
- o_mul_a  out  NB_DATA  latched operand A to the multiplier.
- o_mul_b  out  NB_DATA  latched operand B to the multiplier.
- i_mul_done  in  1  one-cycle completion pulse from the multiplier.
- i_mul_prod  in  2*NB_DATA  product; valid in the i_mul_done cycle.
- o_rsp_valid  out  1  response valid.
- o_rsp_id  out  $clog2(N_REQ)  requester index of the response.
- o_rsp_prod  out  2*NB_DATA  captured product; zero on error.
- o_rsp_err  out  1  watchdog timeout flag.
- i_rsp_ready  in  1  consumer accepts the response.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - State goes to IDLE; round-robin pointer goes to 0 (requester 0 has highest priority first).
  - All outputs are 0 from the following cycle.
  - Reset mid-operation abandons the transaction with no response. A late i_mul_done is ignored in IDLE.
- FSM states are IDLE, ISSUE, WAIT, RESP, all registered.
- IDLE:
  - If |i_req, select the first asserted requester searching upward from the pointer, wrapping from N_REQ-1 to 0.
  - Latch its op_a/op_b into o_mul_a/o_mul_b and latch its ID.
  - Go to ISSUE. o_gnt[id] is asserted for exactly that next cycle (the first ISSUE cycle).
  - Otherwise stay in IDLE.
- ISSUE: o_mul_start=1 for one cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - Watchdog counter increments every cycle.
  - If i_mul_done: capture i_mul_prod, set err=0, go to RESP.
  - Else if counter == TIMEOUT-1: set prod=0, err=1, go to RESP.
  - If i_mul_done and timeout coincide, done wins (err=0).
- RESP:
  - o_rsp_valid=1; id, prod and err are held stable while valid && !ready.
  - On i_rsp_ready=1: set pointer = (id+1) mod N_REQ and go to IDLE.
  - o_rsp_valid drops in the next cycle.
- Latency:
  - Request seen in IDLE at cycle t: grant and start at t+1, WAIT from t+2.
  - With done at cycle d and ready high: o_rsp_valid at d+1, back to IDLE at d+2.
- Operand latching:
  - i_op_* is sampled only in the selecting IDLE cycle; later changes are ignored.
  - i_req deasserting before grant drops the request, with no grant.
- o_mul_a/o_mul_b hold their value until the next selection.
- i_mul_done outside WAIT is ignored.
- Fairness: a continuously requesting client waits at most N_REQ-1 transactions.
- A requester may be granted again only after all other active requesters have been served.
- o_busy = (state != IDLE).

Decomposition:
- Shared package bsm_pkg holds:
  - state encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, RESP=2'd3;
  - an ID width function wrapping $clog2(N_REQ);
  - default NB_DATA.
- One sub-module, rr_select: combinational round-robin priority picker.
  - Inputs: req vector and pointer.
  - Outputs: one-hot select, index and any flag.
  - Reusable by other shared-resource arbiters.

Test Plan:
- Single request: i_req=4'b0100, op_a[2]=4'd5, op_b[2]=4'd3; multiplier model gives done after 4 cycles with prod=8'd15 → o_gnt=4'b0100 for 1 cycle, one o_mul_start, then o_rsp_valid with id=2, prod=15, err=0.
- Round-robin: i_req=4'b1111 held, model product = a*b → grants in order 0,1,2,3,0; no requester is granted twice before all four are served.
- Backpressure: i_rsp_ready=0 for 5 cycles in RESP → valid, id and prod stay stable; no new grant or start occurs until ready=1.
- Timeout: model never asserts done → after TIMEOUT WAIT cycles, response with err=1, prod=0; the next request is served normally.
- Done/timeout collision: done asserted on the cycle counter==TIMEOUT-1 with prod=8'd42 → err=0, prod=42.
- Reset mid-WAIT: i_rst pulsed for 1 cycle → all outputs 0, a late done produces no response, and the pointer restarts at 0 (i_req=4'b1010 grants requester 1 first).

Source files
------------

// File: rtl/bsm_pkg.sv
// Shared types and helpers for the bit-serial multiplier arbiter.
// Holds the sequencer state encoding, the default operand width and the requester-ID width helper.
package bsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int NB_DATA_DEF = 4;

  // Width of a requester index, never narrower than one bit.
  function automatic int id_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/bsm_arbiter_rr_select.sv
// Combinational round-robin picker: first asserted request at or above the pointer, wrapping to 0.
// Returns the grant as one-hot, as an index, and whether any request was found.
module rr_select
  import bsm_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]            req_i,
  input  logic [id_width(N_REQ)-1:0]  ptr_i,
  output logic [N_REQ-1:0]            sel_o,
  output logic [id_width(N_REQ)-1:0]  idx_o,
  output logic                        any_o
);

  localparam int IW = id_width(N_REQ);

  logic [IW:0]   sum_s;
  logic [IW-1:0] cand_s;

  // Walk candidates ptr, ptr+1, ... modulo N_REQ and keep the first hit.
  always_comb begin
    sel_o  = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    sum_s  = '0;
    cand_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sum_s = {1'b0, ptr_i} + (IW+1)'(i);
      if (sum_s >= (IW+1)'(N_REQ)) begin
        sum_s = sum_s - (IW+1)'(N_REQ);
      end else begin
        sum_s = sum_s;
      end
      cand_s = sum_s[IW-1:0];
      if (!any_o && req_i[cand_s]) begin
        any_o         = 1'b1;
        idx_o         = cand_s;
        sel_o[cand_s] = 1'b1;
      end else begin
        any_o = any_o;
      end
    end
  end

endmodule

// File: rtl/bsm_arbiter.sv
// Round-robin sequencer sharing one bit-serial multiplier among N_REQ requesters,
// with a watchdog on the multiplier's done pulse and a valid/ready response port.
module bsm_arbiter
  import bsm_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [N_REQ-1:0]              i_req,
  input  logic [N_REQ*NB_DATA-1:0]      i_op_a,
  input  logic [N_REQ*NB_DATA-1:0]      i_op_b,
  output logic [N_REQ-1:0]              o_gnt,
  output logic                          o_mul_start,
  output logic [NB_DATA-1:0]            o_mul_a,
  output logic [NB_DATA-1:0]            o_mul_b,
  input  logic                          i_mul_done,
  input  logic [2*NB_DATA-1:0]          i_mul_prod,
  output logic                          o_rsp_valid,
  output logic [id_width(N_REQ)-1:0]    o_rsp_id,
  output logic [2*NB_DATA-1:0]          o_rsp_prod,
  output logic                          o_rsp_err,
  input  logic                          i_rsp_ready,
  output logic                          o_busy
);

  localparam int IW = id_width(N_REQ);
  localparam int PW = 2 * NB_DATA;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] ID_LAST  = IW'(N_REQ - 1);

  state_e             state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      id_q, id_d;
  logic [NB_DATA-1:0] a_q, a_d, b_q, b_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]      prod_q, prod_d;
  logic               err_q, err_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               start_q, valid_q, busy_q;

  logic [N_REQ-1:0]   sel_s;
  logic [IW-1:0]      idx_s;
  logic               any_s;
  logic [NB_DATA-1:0] a_sel_s, b_sel_s;
  logic [IW-1:0]      ptr_next_s;

  rr_select #(
    .N_REQ (N_REQ)
  ) u_rr_select (
    .req_i (i_req),
    .ptr_i (ptr_q),
    .sel_o (sel_s),
    .idx_o (idx_s),
    .any_o (any_s)
  );

  // Operand mux driven by the one-hot selection.
  always_comb begin
    a_sel_s = '0;
    b_sel_s = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel_s[k]) begin
        a_sel_s = i_op_a[k*NB_DATA +: NB_DATA];
        b_sel_s = i_op_b[k*NB_DATA +: NB_DATA];
      end else begin
        a_sel_s = a_sel_s;
        b_sel_s = b_sel_s;
      end
    end
  end

  assign ptr_next_s = (id_q == ID_LAST) ? '0 : id_q + IW'(1);

  // Sequencer next-state logic; done takes precedence over the watchdog.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    gnt_d   = '0;
    prod_d  = prod_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (any_s) begin
          state_d = ISSUE;
          id_d    = idx_s;
          a_d     = a_sel_s;
          b_d     = b_sel_s;
          gnt_d   = sel_s;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (i_mul_done) begin
          prod_d  = i_mul_prod;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        if (i_rsp_ready) begin
          ptr_d   = ptr_next_s;
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; strobes are decoded from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      gnt_q   <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      start_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
      gnt_q   <= gnt_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      start_q <= (state_d == ISSUE);
      valid_q <= (state_d == RESP);
      busy_q  <= (state_d != IDLE);
    end
  end

  assign o_gnt       = gnt_q;
  assign o_mul_start = start_q;
  assign o_mul_a     = a_q;
  assign o_mul_b     = b_q;
  assign o_rsp_valid = valid_q;
  assign o_rsp_id    = id_q;
  assign o_rsp_prod  = prod_q;
  assign o_rsp_err   = err_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_bsm_arbiter.sv
// Directed bench for bsm_arbiter: round-robin order, latching, backpressure, watchdog,
// done/timeout collision and mid-transaction reset, against a simple multiplier model.
module tb_bsm_arbiter;

  localparam int NB = 4;
  localparam int NR = 4;
  localparam int TO = 32;

  logic              i_clk = 1'b0;
  logic              i_rst;
  logic [NR-1:0]     i_req;
  logic [NR*NB-1:0]  i_op_a, i_op_b;
  logic [NR-1:0]     o_gnt;
  logic              o_mul_start;
  logic [NB-1:0]     o_mul_a, o_mul_b;
  logic              i_mul_done;
  logic [2*NB-1:0]   i_mul_prod;
  logic              o_rsp_valid;
  logic [1:0]        o_rsp_id;
  logic [2*NB-1:0]   o_rsp_prod;
  logic              o_rsp_err;
  logic              i_rsp_ready;
  logic              o_busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_clk = ~i_clk;

  bsm_arbiter #(.NB_DATA(NB), .N_REQ(NR), .TIMEOUT(TO)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_req),
    .i_op_a      (i_op_a),
    .i_op_b      (i_op_b),
    .o_gnt       (o_gnt),
    .o_mul_start (o_mul_start),
    .o_mul_a     (o_mul_a),
    .o_mul_b     (o_mul_b),
    .i_mul_done  (i_mul_done),
    .i_mul_prod  (i_mul_prod),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_prod  (o_rsp_prod),
    .o_rsp_err   (o_rsp_err),
    .i_rsp_ready (i_rsp_ready),
    .o_busy      (o_busy)
  );

  // Multiplier model: done pulse mdl_lat cycles after the start pulse.
  int         mdl_lat     = 4;
  bit         mdl_never   = 1'b0;
  bit         mdl_ovr     = 1'b0;
  logic [7:0] mdl_ovr_val = 8'd0;
  int         mdl_cnt     = 0;
  logic [7:0] mdl_prod    = 8'd0;

  initial begin
    i_mul_done = 1'b0;
    i_mul_prod = 8'd0;
    forever begin
      @(negedge i_clk);
      i_mul_done = 1'b0;
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          i_mul_done = 1'b1;
          i_mul_prod = mdl_ovr ? mdl_ovr_val : mdl_prod;
        end
      end
      if (o_mul_start && !mdl_never) begin
        mdl_cnt  = mdl_lat;
        mdl_prod = o_mul_a * o_mul_b;
      end
    end
  end

  int gnt_pulses = 0, start_pulses = 0, valid_cycles = 0;

  initial begin
    forever begin
      @(negedge i_clk);
      if (o_gnt != '0) gnt_pulses++;
      if (o_mul_start) start_pulses++;
      if (o_rsp_valid) valid_cycles++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge i_clk);
    #1;
  endtask

  task automatic wait_gnt(input int exp_id, input string tag);
    int n = 0;
    while (o_gnt == '0 && n < 20) begin
      step();
      n++;
    end
    check_eq({tag, "_gnt"}, 32'(o_gnt), 32'(1) << exp_id);
    check_eq({tag, "_start"}, 32'(o_mul_start), 32'd1);
  endtask

  task automatic wait_rsp(input int exp_id, input int exp_prod, input bit exp_err,
                          input string tag, output int cyc);
    cyc = 0;
    while (!o_rsp_valid && cyc < TO + 10) begin
      step();
      cyc++;
    end
    check_eq({tag, "_valid"}, 32'(o_rsp_valid), 32'd1);
    check_eq({tag, "_id"}, 32'(o_rsp_id), 32'(exp_id));
    check_eq({tag, "_prod"}, 32'(o_rsp_prod), 32'(exp_prod));
    check_eq({tag, "_err"}, 32'(o_rsp_err), 32'(exp_err));
  endtask

  task automatic finish_rsp(input string tag);
    step();
    check_eq({tag, "_vdrop"}, 32'(o_rsp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench watchdog");
  end

  initial begin
    int cyc, g0, s0, v0, id;
    i_rst = 1'b1;
    i_req = '0;
    i_rsp_ready = 1'b1;
    for (int k = 0; k < NR; k++) begin
      i_op_a[k*NB +: NB] = NB'(k + 2);
      i_op_b[k*NB +: NB] = NB'(k + 3);
    end
    step();
    step();
    i_rst = 1'b0;
    check_eq("rst_gnt", 32'(o_gnt), 32'd0);
    check_eq("rst_start", 32'(o_mul_start), 32'd0);
    check_eq("rst_valid", 32'(o_rsp_valid), 32'd0);
    check_eq("rst_busy", 32'(o_busy), 32'd0);

    // Round robin with all four requesting: 0,1,2,3,0; products (k+2)*(k+3).
    mdl_lat = 3;
    i_req = 4'b1111;
    g0 = gnt_pulses;
    for (int k = 0; k < 5; k++) begin
      id = k % NR;
      wait_gnt(id, "rr");
      wait_rsp(id, (id + 2) * (id + 3), 1'b0, "rr", cyc);
      check_eq("rr_latency", 32'(cyc), 32'd4);
      finish_rsp("rr");
    end
    i_req = '0;
    check_eq("rr_gnt_count", 32'(gnt_pulses - g0), 32'd5);

    // Single request from requester 2: 5*3 = 15, done 4 cycles after start.
    i_op_a[2*NB +: NB] = 4'd5;
    i_op_b[2*NB +: NB] = 4'd3;
    mdl_lat = 4;
    i_req = 4'b0100;
    wait_gnt(2, "single");
    i_req = '0;
    i_op_a[2*NB +: NB] = 4'd15;
    s0 = start_pulses;
    check_eq("single_mul_a", 32'(o_mul_a), 32'd5);
    check_eq("single_mul_b", 32'(o_mul_b), 32'd3);
    check_eq("single_busy", 32'(o_busy), 32'd1);
    step();
    check_eq("single_gnt_pulse", 32'(o_gnt), 32'd0);
    check_eq("single_start_pulse", 32'(o_mul_start), 32'd0);
    wait_rsp(2, 15, 1'b0, "single", cyc);
    check_eq("single_latency", 32'(cyc + 1), 32'd5);
    check_eq("single_one_start", 32'(start_pulses - s0), 32'd0);
    finish_rsp("single");
    check_eq("single_idle", 32'(o_busy), 32'd0);
    i_op_a[2*NB +: NB] = 4'd4;
    i_op_b[2*NB +: NB] = 4'd5;

    // Backpressure: requester 0 (pointer at 3 wraps to 0), requester 3 waits behind it.
    i_rsp_ready = 1'b0;
    mdl_lat = 2;
    i_req = 4'b0001;
    wait_gnt(0, "bp");
    i_req = 4'b1000;
    wait_rsp(0, 6, 1'b0, "bp", cyc);
    g0 = gnt_pulses;
    s0 = start_pulses;
    for (int k = 0; k < 5; k++) begin
      step();
      check_eq("bp_hold_valid", 32'(o_rsp_valid), 32'd1);
      check_eq("bp_hold_id", 32'(o_rsp_id), 32'd0);
      check_eq("bp_hold_prod", 32'(o_rsp_prod), 32'd6);
    end
    check_eq("bp_no_gnt", 32'(gnt_pulses - g0), 32'd0);
    check_eq("bp_no_start", 32'(start_pulses - s0), 32'd0);
    i_rsp_ready = 1'b1;
    finish_rsp("bp");
    wait_gnt(3, "bp_next");
    i_req = '0;
    wait_rsp(3, 30, 1'b0, "bp_next", cyc);
    finish_rsp("bp_next");

    // Watchdog: no done ever; error response TIMEOUT+1 cycles after the grant.
    mdl_never = 1'b1;
    i_req = 4'b0010;
    wait_gnt(1, "to");
    i_req = '0;
    wait_rsp(1, 0, 1'b1, "to", cyc);
    check_eq("to_latency", 32'(cyc), 32'(TO + 1));
    finish_rsp("to");
    mdl_never = 1'b0;
    mdl_lat = 3;
    i_req = 4'b0100;
    wait_gnt(2, "after_to");
    i_req = '0;
    wait_rsp(2, 20, 1'b0, "after_to", cyc);
    finish_rsp("after_to");

    // Done on the last watchdog cycle wins (pointer 3 wraps round to requester 1).
    mdl_lat = TO;
    mdl_ovr = 1'b1;
    mdl_ovr_val = 8'd42;
    i_req = 4'b0010;
    wait_gnt(1, "coll");
    i_req = '0;
    wait_rsp(1, 42, 1'b0, "coll", cyc);
    check_eq("coll_latency", 32'(cyc), 32'(TO + 1));
    finish_rsp("coll");
    mdl_ovr = 1'b0;

    // Reset mid-WAIT with pointer at 2: late done ignored, pointer back to 0.
    mdl_lat = 10;
    i_req = 4'b0100;
    wait_gnt(2, "mid");
    i_req = '0;
    step();
    step();
    step();
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    v0 = valid_cycles;
    check_eq("mid_rst_busy", 32'(o_busy), 32'd0);
    check_eq("mid_rst_mul_a", 32'(o_mul_a), 32'd0);
    check_eq("mid_rst_prod", 32'(o_rsp_prod), 32'd0);
    check_eq("mid_rst_start", 32'(o_mul_start), 32'd0);
    for (int k = 0; k < 12; k++) begin
      step();
    end
    check_eq("mid_no_rsp", 32'(valid_cycles - v0), 32'd0);
    mdl_lat = 3;
    i_req = 4'b1010;
    wait_gnt(1, "mid_ptr");
    i_req = '0;
    wait_rsp(1, 12, 1'b0, "mid_ptr", cyc);
    finish_rsp("mid_ptr");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
